dvi_encoder: RTL and testbench
==============================

DVI_ENCODER -- requirements
Module: dvi_encoder

Interface
REQ-001 SHALL have parameter COLOR_BITS, default 4: width of each incoming colour component; values 1..8.
REQ-002 SHALL have port clk, input, 1: pixel clock, the single clock of the block; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports vga_r, vga_g, vga_b, input, COLOR_BITS each: pixel colour, already forced to 0 outside the active area upstream.
REQ-005 SHALL have ports vga_hs, vga_vs, input, 1 each: sync signals, active-low as produced upstream, passed through unmodified.
REQ-006 SHALL have port vga_de, input, 1: high during active pixels.
REQ-007 SHALL have ports tmds_r, tmds_g, tmds_b, output, 10 each: parallel TMDS symbols, bit 0 transmitted first, feeding the serializer.

Function
REQ-008 SHALL expand each component to 8 bits by repeating its bits from the MSB down, truncated to 8 bits (4-bit 0xA -> 0xAA, 0xF -> 0xFF, 0x0 -> 0x00).
REQ-009 SHALL encode the three channels with identical logic, one instance per channel; blue carries {C1,C0} = {vga_vs, vga_hs}; red and green carry {C1,C0} = 00.
REQ-010 Stage 1 SHALL register q_m[8:0], the ones count of q_m[7:0], de and C1C0 from the current input.
REQ-011 Stage 1 SHALL use XNOR chaining with q_m[8]=0 when ones(D)>4, or when ones(D)==4 and D[0]==0; otherwise it SHALL use XOR chaining with q_m[8]=1; q_m[0]=D[0].
REQ-012 Stage 2 SHALL register the 10-bit output and the running disparity cnt, a signed 6-bit value; N1 and N0 are the ones and zeros counts of q_m[7:0].
REQ-013 When de=1 and (cnt==0 or N1==N0), stage 2 SHALL output {~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]} and SHALL add (N1-N0) to cnt if q_m[8]=1, else add (N0-N1).
REQ-014 When de=1 and ((cnt>0 and N1>N0) or (cnt<0 and N0>N1)), stage 2 SHALL output {1, q_m[8], ~q_m[7:0]} and SHALL set cnt = cnt + 2*q_m[8] + (N0-N1).
REQ-015 When de=1 and neither REQ-013 nor REQ-014 applies, stage 2 SHALL output {0, q_m[8], q_m[7:0]} and SHALL set cnt = cnt - 2*(~q_m[8]) + (N1-N0).
REQ-016 When de=0, stage 2 SHALL output the control symbol for C1C0 and SHALL clear cnt to 0: 00 -> 10'b1101010100, 01 -> 10'b0010101011, 10 -> 10'b0101010100, 11 -> 10'b1010101011.
REQ-017 Latency SHALL be exactly 2 clocks from input sample to output for data, de and sync alike, with no skew between channels.
REQ-018 The de edges SHALL need no special handling: the first active pixel after blanking starts from cnt=0.
REQ-019 cnt SHALL stay within -10..+10 for any input sequence; no saturation logic is required.

Reset
REQ-020 While reset is high, all three outputs SHALL be 10'b1101010100, every cnt SHALL be 0, and the pipeline de and C registers SHALL be 0.
REQ-021 Reset asserted mid-line SHALL take effect immediately; after reset is released, valid symbols SHALL appear 2 clocks after the first sampled input.

Structure
REQ-022 The four control-symbol constants and the COLOR_BITS default SHALL live in a shared package, dvi_pkg.
REQ-023 Per-channel logic SHALL be a sub-module tmds_channel (ports clk, reset, d[7:0], c[1:0], de, q[9:0]), instantiated three times by dvi_encoder.
REQ-024 The serializer and the clock-domain crossing SHALL stay outside this block.

Verification
REQ-025 Reset test: assert reset asynchronously mid-frame -> all outputs 0x354 (1101010100) at once; after release, de=0 with hs=vs=1 -> tmds_b=0x2AB and tmds_r=tmds_g=0x354 two clocks later.
REQ-026 Single pixel, cnt=0, blue=0x0 -> tmds_b=0x100 and cnt=-8; a second 0x0 -> 0x3FF and cnt=+2.
REQ-027 Single pixel, cnt=0, red=0xF -> tmds_r=0x200 and cnt=-8.
REQ-028 Sync test: sweep de=0 over all four {vs,hs} combinations -> tmds_b takes each control symbol of REQ-016 after 2 clocks, and red and green stay 0x354.
REQ-029 Randomised 640x480 frame checked against a reference model -> bit-exact symbols, |cnt|<=10, cnt=0 after every blanking interval, decoded pixels equal the expanded inputs.

Source files
------------

// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI encoder: default colour depth, the four TMDS
// control symbols (blanking words) and small helpers used by every channel.
package dvi_pkg;

  localparam int COLOR_BITS_DEFAULT = 4;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: stage 1 builds the transition-minimised word, stage 2 picks
// DC-balancing inversion or a control symbol. Two-clock latency, no stalls.
module tmds_channel
  import dvi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic [1:0] c,
  input  logic       de,
  output logic [9:0] q
);

  logic [3:0]        d_ones;
  logic              use_xnor;
  logic [8:0]        qm_d, qm_q;
  logic [3:0]        n1_d, n1_q;
  logic              de_q;
  logic [1:0]        c_q;
  logic signed [5:0] diff;
  logic signed [5:0] cnt_d, cnt_q;
  logic [9:0]        q_d, q_q;

  always_comb begin
    d_ones   = ones8(d);
    use_xnor = (d_ones > 4'd4) || ((d_ones == 4'd4) && !d[0]);
    qm_d     = '0;
    qm_d[0]  = d[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = qm_d[i-1] ^ d[i] ^ use_xnor;
    end
    qm_d[8]  = ~use_xnor;
    n1_d     = ones8(qm_d[7:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qm_q <= '0;
      n1_q <= '0;
      de_q <= 1'b0;
      c_q  <= 2'b00;
    end else begin
      qm_q <= qm_d;
      n1_q <= n1_d;
      de_q <= de;
      c_q  <= c;
    end
  end

  // diff is N1 - N0 of q_m[7:0], i.e. 2*N1 - 8
  always_comb begin
    diff  = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
    q_d   = ctrl_symbol(c_q);
    cnt_d = '0;
    if (de_q) begin
      if ((cnt_q == 6'sd0) || (n1_q == 4'd4)) begin
        q_d   = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if (((cnt_q > 6'sd0) && (n1_q > 4'd4)) ||
                   ((cnt_q < 6'sd0) && (n1_q < 4'd4))) begin
        q_d   = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q + (qm_q[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
        q_d   = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q - (qm_q[8] ? 6'sd0 : 6'sd2) + diff;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q   <= CTRL_00;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dvi_encoder.sv
// DVI encoder: expands VGA colour to 8 bits and TMDS-encodes three channels in
// lockstep, two clocks from input to 10-bit symbols; sync rides on blue.
module dvi_encoder
  import dvi_pkg::*;
#(
  parameter int COLOR_BITS = COLOR_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COLOR_BITS-1:0] vga_r,
  input  logic [COLOR_BITS-1:0] vga_g,
  input  logic [COLOR_BITS-1:0] vga_b,
  input  logic                  vga_hs,
  input  logic                  vga_vs,
  input  logic                  vga_de,
  output logic [9:0]            tmds_r,
  output logic [9:0]            tmds_g,
  output logic [9:0]            tmds_b
);

  logic [7:0] r8, g8, b8;

  // Replicate each component MSB-first so full scale maps to 0xFF
  for (genvar i = 0; i < 8; i++) begin : g_expand
    localparam int SRC = COLOR_BITS - 1 - (i % COLOR_BITS);
    assign r8[7-i] = vga_r[SRC];
    assign g8[7-i] = vga_g[SRC];
    assign b8[7-i] = vga_b[SRC];
  end

  tmds_channel u_red (
    .clk   (clk),
    .reset (reset),
    .d     (r8),
    .c     (2'b00),
    .de    (vga_de),
    .q     (tmds_r)
  );

  tmds_channel u_green (
    .clk   (clk),
    .reset (reset),
    .d     (g8),
    .c     (2'b00),
    .de    (vga_de),
    .q     (tmds_g)
  );

  tmds_channel u_blue (
    .clk   (clk),
    .reset (reset),
    .d     (b8),
    .c     ({vga_vs, vga_hs}),
    .de    (vga_de),
    .q     (tmds_b)
  );

endmodule

// File: tb/tb_dvi_encoder.sv
// Bench for dvi_encoder: directed literal cases plus a randomised frame checked
// every cycle against a behavioural TMDS model and a symbol decoder.
module tb_dvi_encoder;

  localparam int CB = 4;
  localparam logic [CB-1:0] Z  = '0;
  localparam logic [CB-1:0] MX = '1;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic [CB-1:0] vga_r  = '0;
  logic [CB-1:0] vga_g  = '0;
  logic [CB-1:0] vga_b  = '0;
  logic          vga_hs = 1'b1;
  logic          vga_vs = 1'b1;
  logic          vga_de = 1'b0;
  logic [9:0]    tmds_r, tmds_g, tmds_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] ctrl_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  always #5 clk = ~clk;

  dvi_encoder #(.COLOR_BITS(CB)) dut (
    .clk    (clk),
    .reset  (reset),
    .vga_r  (vga_r),
    .vga_g  (vga_g),
    .vga_b  (vga_b),
    .vga_hs (vga_hs),
    .vga_vs (vga_vs),
    .vga_de (vga_de),
    .tmds_r (tmds_r),
    .tmds_g (tmds_g),
    .tmds_b (tmds_b)
  );

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=0x%03h exp=0x%03h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] expand(input logic [CB-1:0] v);
    logic [8*CB-1:0] rep;
    rep = {8{v}};
    return rep[8*CB-1 -: 8];
  endfunction

  function automatic logic [9:0] encode(input logic [7:0] d, input logic [1:0] c,
                                        input logic de, input int cnt_in, output int cnt_out);
    int n1, m1, m0;
    logic inv;
    logic [8:0] qm;
    if (!de) begin
      cnt_out = 0;
      return ctrl_tab[c];
    end
    n1  = $countones(d);
    inv = (n1 > 4) || (n1 == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !inv;
    m1 = $countones(qm[7:0]);
    m0 = 8 - m1;
    if (cnt_in == 0 || m1 == m0) begin
      cnt_out = qm[8] ? cnt_in + (m1 - m0) : cnt_in + (m0 - m1);
      return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    end
    if ((cnt_in > 0 && m1 > m0) || (cnt_in < 0 && m0 > m1)) begin
      cnt_out = cnt_in + (qm[8] ? 2 : 0) + (m0 - m1);
      return {1'b1, qm[8], ~qm[7:0]};
    end
    cnt_out = cnt_in - (qm[8] ? 0 : 2) + (m1 - m0);
    return {1'b0, qm[8], qm[7:0]};
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] x, d;
    x    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = x[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    return d;
  endfunction

  typedef struct packed {
    logic             de;
    logic [2:0][9:0]  sym;
    logic [2:0][7:0]  pix;
  } exp_t;

  exp_t pipe_q[$];
  int   mcnt[3];
  int   disp[3];

  // Compare process: one model step per sampled input, checked two clocks later
  always @(negedge clk) begin
    exp_t          e;
    logic [9:0]    got [3];
    logic [CB-1:0] in_c [3];
    int            nc;
    got  = '{tmds_r, tmds_g, tmds_b};
    in_c = '{vga_r, vga_g, vga_b};
    if (reset) begin
      for (int ch = 0; ch < 3; ch++) begin
        chk("reset_sym", got[ch], 10'h354);
        mcnt[ch] = 0;
        disp[ch] = 0;
      end
      pipe_q.delete();
    end else begin
      e.de = vga_de;
      for (int ch = 0; ch < 3; ch++) begin
        e.pix[ch] = expand(in_c[ch]);
        e.sym[ch] = encode(e.pix[ch], (ch == 2) ? {vga_vs, vga_hs} : 2'b00,
                           vga_de, mcnt[ch], nc);
        mcnt[ch]  = nc;
      end
      pipe_q.push_back(e);
      if (pipe_q.size() == 3) begin
        e = pipe_q.pop_front();
        for (int ch = 0; ch < 3; ch++) begin
          chk("symbol", got[ch], e.sym[ch]);
          if (e.de) begin
            chk("decoded_pixel", {2'b00, decode(got[ch])}, {2'b00, e.pix[ch]});
            disp[ch] += 2 * $countones(got[ch]) - 10;
            n_tests++;
            if (disp[ch] > 10 || disp[ch] < -10) begin
              n_fail++;
              $display("FAIL disparity ch=%0d got=%0d limit=+-10", ch, disp[ch]);
            end
          end else begin
            disp[ch] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [CB-1:0] r, input logic [CB-1:0] g, input logic [CB-1:0] b,
                      input logic hs, input logic vs, input logic de);
    vga_r  = r;
    vga_g  = g;
    vga_b  = b;
    vga_hs = hs;
    vga_vs = vs;
    vga_de = de;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CB-1:0] rnd_comp(input int mode);
    case (mode)
      1:       return ($urandom_range(0, 1) == 1) ? MX : Z;
      2:       return CB'($urandom_range(0, 2));
      default: return CB'($urandom);
    endcase
  endfunction

  initial begin
    logic [1:0] v;
    logic       de;
    int         mode;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      de = (k >= 4);
      step(de ? rnd_comp(0) : Z, de ? rnd_comp(1) : Z, de ? rnd_comp(0) : Z, 1'b1, 1'b1, de);
    end

    // asynchronous reset in the middle of active video
    #2 reset = 1'b1;
    #1;
    chk("async_reset_r", tmds_r, 10'h354);
    chk("async_reset_g", tmds_g, 10'h354);
    chk("async_reset_b", tmds_b, 10'h354);
    vga_r = Z; vga_g = Z; vga_b = Z; vga_hs = 1'b1; vga_vs = 1'b1; vga_de = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    step(Z, Z, Z, 1'b1, 1'b1, 1'b0);
    step(Z, Z, Z, 1'b1, 1'b1, 1'b0);
    chk("post_reset_b", tmds_b, 10'h2AB);
    chk("post_reset_r", tmds_r, 10'h354);
    chk("post_reset_g", tmds_g, 10'h354);
    step(Z, Z, Z, 1'b1, 1'b1, 1'b1);
    step(Z, Z, Z, 1'b1, 1'b1, 1'b1);
    chk("blue_zero_first", tmds_b, 10'h100);
    step(Z, Z, Z, 1'b1, 1'b1, 1'b0);
    chk("blue_zero_second", tmds_b, 10'h3FF);
    step(MX, Z, Z, 1'b1, 1'b1, 1'b1);
    step(Z, Z, Z, 1'b0, 1'b0, 1'b0);
    chk("red_full", tmds_r, 10'h200);

    for (int k = 0; k < 5; k++) begin
      v = 2'((k < 4) ? k : 3);
      step(Z, Z, Z, v[0], v[1], 1'b0);
      if (k >= 1) begin
        chk("sync_b", tmds_b, ctrl_tab[k-1]);
        chk("sync_r", tmds_r, 10'h354);
        chk("sync_g", tmds_g, 10'h354);
      end
    end
    step(4'hA, Z, Z, 1'b1, 1'b1, 1'b1);
    step(Z, Z, Z, 1'b1, 1'b1, 1'b0);
    chk("red_0xA", tmds_r, 10'h233);

    // reduced-height 640-wide frame: 40 active lines, 5 blanking lines
    for (int line = 0; line < 45; line++) begin
      mode = line % 4;
      for (int x = 0; x < 800; x++) begin
        de = (line < 40) && (x < 640);
        step(de ? rnd_comp(mode) : Z, de ? rnd_comp(mode) : Z, de ? rnd_comp(mode) : Z,
             !(x >= 656 && x < 752), !(line >= 42 && line < 44), de);
      end
    end
    repeat (4) step(Z, Z, Z, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
